// File: rtl/audio_adc_sampler.sv
// MCP3202-class SPI ADC front end: converts left then right once per sample period and
// presents the pair as signed 16-bit PCM with a one-cycle valid strobe.
module audio_adc_sampler #(
  parameter int unsigned CLK_DIV    = 7,
  parameter int unsigned SAMPLE_DIV = 562
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        adc_clk,
  output logic        adc_cs,
  output logic        adc_mosi,
  input  logic        adc_miso,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int unsigned TickW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned HalfW = $clog2(CLK_DIV);
  localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(CLK_DIV - 1);
  localparam logic [5:0] PhaseLast = 6'd33;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap, StDone} state_e;

  state_e             state_q;
  logic [TickW-1:0]   tick_cnt_q;
  logic [HalfW-1:0]   half_q;
  logic [5:0]         phase_q;
  logic               channel_q;
  logic               miso_meta_q, miso_sync_q;
  logic [11:0]        shift_q, left_q;
  logic               tick, half_end, capture;
  logic [5:0]         phase_inc;

  assign tick      = (tick_cnt_q == TickLast);
  assign half_end  = (half_q == HalfLast);
  assign phase_inc = phase_q + 6'd1;
  // Rising edge lands at half_q==0 of an odd phase; two flops later the bit sits in miso_sync_q.
  assign capture   = (state_q == StShift) && phase_q[0] && (half_q == HalfW'(1)) &&
                     (phase_q[5:1] >= 5'd5);

  function automatic logic cmd_bit(input logic [4:0] cyc, input logic ch);
    case (cyc)
      5'd0, 5'd1, 5'd3: return 1'b1;
      5'd2:             return ch;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] recode(input logic [11:0] d);
    return {~d[11], d[10:0], 4'b0000};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick ? '0 : tick_cnt_q + TickW'(1);
      miso_meta_q <= adc_miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      half_q       <= '0;
      phase_q      <= '0;
      channel_q    <= 1'b0;
      shift_q      <= '0;
      left_q       <= '0;
      adc_clk      <= 1'b0;
      adc_cs       <= 1'b1;
      adc_mosi     <= 1'b0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // Ticks are never queued: a busy FSM simply drops them.
      overrun      <= tick && (state_q != StIdle);
      sample_valid <= 1'b0;
      half_q       <= (state_q == StIdle || state_q == StDone || half_end) ?
                      '0 : half_q + HalfW'(1);
      if (capture) shift_q <= {shift_q[10:0], miso_sync_q};
      case (state_q)
        StIdle: begin
          if (tick && enable) begin
            state_q   <= StSetup;
            channel_q <= 1'b0;
            adc_cs    <= 1'b0;
            adc_mosi  <= 1'b1;
          end
        end
        StSetup: begin
          if (half_end) begin
            state_q <= StShift;
            phase_q <= '0;
          end
        end
        StShift: begin
          if (half_end) begin
            if (phase_q == PhaseLast) begin
              state_q  <= StHold;
              adc_clk  <= 1'b0;
              adc_mosi <= 1'b0;
            end else begin
              phase_q <= phase_inc;
              adc_clk <= phase_inc[0];
              if (!phase_inc[0]) adc_mosi <= cmd_bit(phase_inc[5:1], channel_q);
            end
          end
        end
        StHold: begin
          if (half_end) begin
            state_q <= StGap;
            adc_cs  <= 1'b1;
          end
        end
        StGap: begin
          if (half_end) begin
            if (!channel_q) begin
              left_q    <= shift_q;
              channel_q <= 1'b1;
              state_q   <= StSetup;
              adc_cs    <= 1'b0;
              adc_mosi  <= 1'b1;
            end else begin
              state_q      <= StDone;
              sample_l     <= recode(left_q);
              sample_r     <= recode(shift_q);
              sample_valid <= 1'b1;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
